// File: rtl/lc3_writeback_stage.sv
// LC-3 writeback stage: source mux, 8x16 register file with two read ports, and NZP condition codes.
// Optional macro WB_READ_BYPASS_EN forwards same-cycle write data onto the read ports.
module lc3_writeback_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  W_Control_in,
  input  logic [15:0] npc,
  input  logic [15:0] aluout,
  input  logic [15:0] pcout,
  input  logic [15:0] memout,
  input  logic        enable_writeback,
  input  logic [2:0]  sr1,
  input  logic [2:0]  sr2,
  input  logic [2:0]  dr,
  output logic [15:0] d1,
  output logic [15:0] d2,
  output logic [2:0]  psr
);

  logic [7:0][15:0] regs_q;
  logic [7:0][15:0] regs_d;
  logic [2:0]       psr_q;
  logic [2:0]       psr_d;
  logic [15:0]      wb_data_s;

  function automatic logic [2:0] nzp_of(input logic [15:0] value);
    if (value[15]) begin
      return 3'b100;
    end else if (value == 16'h0000) begin
      return 3'b010;
    end else begin
      return 3'b001;
    end
  endfunction

  // Writeback source select.
  always_comb begin
    case (W_Control_in)
      2'd0:    wb_data_s = aluout;
      2'd1:    wb_data_s = pcout;
      2'd2:    wb_data_s = memout;
      2'd3:    wb_data_s = npc;
      default: wb_data_s = aluout;
    endcase
  end

  // Next-state for the register file and condition codes.
  always_comb begin
    regs_d = regs_q;
    psr_d  = psr_q;
    if (enable_writeback) begin
      regs_d[dr] = wb_data_s;
      psr_d      = nzp_of(wb_data_s);
    end else begin
      regs_d = regs_q;
      psr_d  = psr_q;
    end
  end

  // State registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
      psr_q  <= 3'b000;
    end else begin
      regs_q <= regs_d;
      psr_q  <= psr_d;
    end
  end

  // Read ports.
  always_comb begin
`ifdef WB_READ_BYPASS_EN
    // Forward the pending write, but never while reset holds the file at zero.
    if (!reset && enable_writeback && (sr1 == dr)) begin
      d1 = wb_data_s;
    end else begin
      d1 = regs_q[sr1];
    end
    if (!reset && enable_writeback && (sr2 == dr)) begin
      d2 = wb_data_s;
    end else begin
      d2 = regs_q[sr2];
    end
`else
    d1 = regs_q[sr1];
    d2 = regs_q[sr2];
`endif
  end

  assign psr = psr_q;

endmodule

// File: tb/tb_lc3_writeback_stage.sv
// Self-checking bench for lc3_writeback_stage: directed scenarios followed by random traffic
// compared against an array-based register-file model.
module tb_lc3_writeback_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  W_Control_in = 2'd0;
  logic [15:0] npc = 16'h0000, aluout = 16'h0000, pcout = 16'h0000, memout = 16'h0000;
  logic        enable_writeback = 1'b0;
  logic [2:0]  sr1 = 3'd0, sr2 = 3'd0, dr = 3'd0;
  logic [15:0] d1, d2;
  logic [2:0]  psr;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  logic [15:0] ref_r [8];
  logic [2:0]  ref_psr;

`ifdef WB_READ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  lc3_writeback_stage dut (
    .clock(clock), .reset(reset), .W_Control_in(W_Control_in),
    .npc(npc), .aluout(aluout), .pcout(pcout), .memout(memout),
    .enable_writeback(enable_writeback), .sr1(sr1), .sr2(sr2), .dr(dr),
    .d1(d1), .d2(d2), .psr(psr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] selected();
    logic [15:0] srcs [4];
    srcs[0] = aluout; srcs[1] = pcout; srcs[2] = memout; srcs[3] = npc;
    return srcs[W_Control_in];
  endfunction

  function automatic logic [2:0] nzp(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  // Advance one edge, updating the model as the spec dictates, and settle 1 time unit after it.
  task automatic step();
    if (enable_writeback && !reset) begin
      ref_r[dr] = selected();
      ref_psr   = nzp(selected());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ref_r[i] = 16'h0000;
    ref_psr = 3'b000;
  endtask

  initial begin
    logic [15:0] exp1, exp2, v;
    model_reset();

    // Writes attempted while reset is held must be ignored, bypass included.
    enable_writeback = 1'b1; aluout = 16'hFFFF; dr = 3'd0; sr1 = 3'd0; sr2 = 3'd7;
    step(); step();
    check("rst_bypass_d1", d1, 16'h0000);
    enable_writeback = 1'b0;
    #1;
    check("rst_d1", d1, 16'h0000);
    check("rst_d2", d2, 16'h0000);
    check("rst_psr", {13'd0, psr}, 16'h0000);
    reset = 1'b0;
    step();
    check("after_rst_psr", {13'd0, psr}, 16'h0000);

    // Negative ALU result into R3.
    W_Control_in = 2'd0; aluout = 16'h8001; dr = 3'd3; enable_writeback = 1'b1;
    step();
    enable_writeback = 1'b0; sr1 = 3'd3; #1;
    check("alu_r3", d1, 16'h8001);
    check("alu_psr", {13'd0, psr}, 16'h0004);

    // Sources 1/2/3 into R1/R2/R4.
    pcout = 16'h3005; memout = 16'h0000; npc = 16'h3001; aluout = 16'h7777;
    for (int s = 1; s <= 3; s++) begin
      W_Control_in = s[1:0];
      dr = (s == 3) ? 3'd4 : s[2:0];
      enable_writeback = 1'b1;
      step();
      enable_writeback = 1'b0; sr1 = dr; sr2 = 3'd3; #1;
      check($sformatf("src%0d_d1", s), d1, (s == 1) ? 16'h3005 : (s == 2) ? 16'h0000 : 16'h3001);
      check($sformatf("src%0d_psr", s), {13'd0, psr}, (s == 2) ? 16'h0002 : 16'h0001);
      check($sformatf("src%0d_r3", s), d2, 16'h8001);
    end

    // Disabled writes leave R5 and psr alone.
    W_Control_in = 2'd0; aluout = 16'hFFFF; dr = 3'd5; enable_writeback = 1'b0;
    repeat (3) step();
    sr1 = 3'd5; #1;
    check("noen_r5", d1, 16'h0000);
    check("noen_psr", {13'd0, psr}, 16'h0001);

    // Same-cycle read of the register being written.
    sr1 = 3'd2; sr2 = 3'd2; dr = 3'd2; aluout = 16'h00AA; enable_writeback = 1'b1; #1;
    check("byp_pre_d1", d1, BYPASS ? 16'h00AA : 16'h0000);
    check("byp_pre_d2", d2, BYPASS ? 16'h00AA : 16'h0000);
    step();
    enable_writeback = 1'b0; #1;
    check("byp_post_d1", d1, 16'h00AA);
    check("byp_post_d2", d2, 16'h00AA);

    // Back-to-back writes to one register: last wins.
    dr = 3'd7; sr1 = 3'd7; enable_writeback = 1'b1;
    aluout = 16'h0000; step();
    check("b2b_first_psr", {13'd0, psr}, 16'h0002);
    aluout = 16'h9000; step();
    enable_writeback = 1'b0; #1;
    check("b2b_last_d1", d1, 16'h9000);
    check("b2b_last_psr", {13'd0, psr}, 16'h0004);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      W_Control_in = 2'($urandom_range(0, 3));
      aluout = 16'($urandom); pcout = 16'($urandom);
      memout = 16'($urandom); npc = 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        v = 16'h0000;
        case (W_Control_in)
          2'd0: aluout = v;
          2'd1: pcout = v;
          2'd2: memout = v;
          default: npc = v;
        endcase
      end
      dr = 3'($urandom_range(0, 7)); sr1 = 3'($urandom_range(0, 7));
      sr2 = ($urandom_range(0, 3) == 0) ? sr1 : 3'($urandom_range(0, 7));
      enable_writeback = 1'($urandom_range(0, 1));
      #1;
      exp1 = (BYPASS && enable_writeback && sr1 == dr) ? selected() : ref_r[sr1];
      exp2 = (BYPASS && enable_writeback && sr2 == dr) ? selected() : ref_r[sr2];
      check("rnd_pre_d1", d1, exp1);
      check("rnd_pre_d2", d2, exp2);
      step();
      check("rnd_psr", {13'd0, psr}, {13'd0, ref_psr});
      enable_writeback = 1'b0; #1;
      check("rnd_post_d1", d1, ref_r[sr1]);
      check("rnd_post_d2", d2, ref_r[sr2]);
    end
    check("rnd_onehot", {15'd0, $onehot(psr)}, 16'h0001);

    // Mid-cycle reset discards everything.
    W_Control_in = 2'd0; aluout = 16'h1234; dr = 3'd6; enable_writeback = 1'b1;
    step();
    enable_writeback = 1'b0; sr2 = 3'd6; sr1 = 3'd3; #1;
    check("r6_written", d2, 16'h1234);
    #2 reset = 1'b1; model_reset(); #1;
    check("midrst_d2", d2, 16'h0000);
    check("midrst_d1", d1, 16'h0000);
    check("midrst_psr", {13'd0, psr}, 16'h0000);
    step();
    reset = 1'b0;
    // First edge after release performs the first write.
    aluout = 16'h0042; dr = 3'd6; enable_writeback = 1'b1;
    step();
    enable_writeback = 1'b0; #1;
    check("first_wr_d2", d2, 16'h0042);
    check("first_wr_psr", {13'd0, psr}, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
